// File: rtl/eth_tx_arbiter_pkg.sv
// Shared definitions for the layer-2 transmit arbiter.
//   EthernetBus     : streaming frame bus (start, data_valid, bytes_valid, data, commit, drop)
//   ETHERTYPE_*     : ethertype values attached to each source
//   arb_state_e     : arbiter grant states
//   src_e           : source index (ARP / IPv4)
package eth_tx_arbiter_pkg;

  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

  // Same field layout as the shared EthernetBus definition used by the MAC framer.
  typedef struct packed {
    logic        start;
    logic        data_valid;
    logic [2:0]  bytes_valid;
    logic [31:0] data;
    logic        commit;
    logic        drop;
  } EthernetBus;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_GRANT_ARP  = 2'd1,
    ST_GRANT_IPV4 = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_ARP  = 1'b0,
    SRC_IPV4 = 1'b1
  } src_e;

endpackage

// File: rtl/eth_tx_arbiter.sv
// Arbitrates the single layer-2 transmit bus between the ARP responder and
// the IPv4 transmit path. The first source to start owns the bus until its
// commit/drop; colliding frames are discarded and counted; a watchdog
// force-drops frames longer than MAX_FRAME_WORDS.
// Ports:
//   clk, rst_n                        : clock, async active-low reset
//   arp_tx_bus / arp_tx_dst_mac       : ARP source frame + destination MAC
//   ipv4_tx_bus / ipv4_tx_dst_mac     : IPv4 source frame + destination MAC
//   tx_l2_bus / tx_l2_dst_mac         : arbitrated frame, 1 cycle latency
//   tx_l2_ethertype                   : ethertype of the granted source
//   perf_arp_sent / perf_ipv4_sent    : committed frames per source (wrapping)
//   perf_collisions / perf_timeouts   : rejected starts / watchdog drops (wrapping)
module eth_tx_arbiter
  import eth_tx_arbiter_pkg::*;
#(
  parameter int unsigned MAX_FRAME_WORDS = 400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  EthernetBus  arp_tx_bus,
  input  logic [47:0] arp_tx_dst_mac,
  input  EthernetBus  ipv4_tx_bus,
  input  logic [47:0] ipv4_tx_dst_mac,
  output EthernetBus  tx_l2_bus,
  output logic [47:0] tx_l2_dst_mac,
  output logic [15:0] tx_l2_ethertype,
  output logic [31:0] perf_arp_sent,
  output logic [31:0] perf_ipv4_sent,
  output logic [31:0] perf_collisions,
  output logic [31:0] perf_timeouts
);

  localparam logic [15:0] MAX_WORDS = 16'(MAX_FRAME_WORDS);

  arb_state_e  state_q, state_d;
  src_e        last_q, last_d;
  logic        ign_arp_q, ign_arp_d;
  logic        ign_ipv4_q, ign_ipv4_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  EthernetBus  bus_q, bus_d;
  logic [47:0] mac_q, mac_d;
  logic [15:0] ethertype_q, ethertype_d;
  logic [31:0] arp_sent_q, arp_sent_d;
  logic [31:0] ipv4_sent_q, ipv4_sent_d;
  logic [31:0] coll_q, coll_d;
  logic [31:0] tmo_q, tmo_d;

  logic        arp_term, ipv4_term, arp_start, ipv4_start;
  logic        grant_ipv4, g_start, g_term, o_start, at_limit;
  EthernetBus  g_bus;
  src_e        win;
  logic [1:0]  coll_inc;

  always_comb begin
    arp_term   = arp_tx_bus.commit | arp_tx_bus.drop;
    ipv4_term  = ipv4_tx_bus.commit | ipv4_tx_bus.drop;
    // An ignored source's start survives only if its own commit/drop
    // releases the ignore flag in the same cycle.
    arp_start  = arp_tx_bus.start & (~ign_arp_q | arp_term);
    ipv4_start = ipv4_tx_bus.start & (~ign_ipv4_q | ipv4_term);

    grant_ipv4 = (state_q == ST_GRANT_IPV4);
    g_bus      = grant_ipv4 ? ipv4_tx_bus : arp_tx_bus;
    g_start    = grant_ipv4 ? ipv4_start : arp_start;
    o_start    = grant_ipv4 ? arp_start : ipv4_start;
    g_term     = g_bus.commit | g_bus.drop;
    at_limit   = g_bus.data_valid & (word_cnt_q == MAX_WORDS);

    state_d     = state_q;
    last_d      = last_q;
    ign_arp_d   = ign_arp_q & ~arp_term;
    ign_ipv4_d  = ign_ipv4_q & ~ipv4_term;
    word_cnt_d  = word_cnt_q;
    bus_d       = '0;
    mac_d       = mac_q;
    ethertype_d = ethertype_q;
    arp_sent_d  = arp_sent_q;
    ipv4_sent_d = ipv4_sent_q;
    tmo_d       = tmo_q;
    win         = SRC_ARP;
    coll_inc    = '0;

    if (state_q == ST_IDLE) begin
      if (arp_start | ipv4_start) begin
        if (arp_start & ipv4_start) begin
          // Tie: the source not granted last time wins.
          win      = (last_q == SRC_IPV4) ? SRC_ARP : SRC_IPV4;
          coll_inc = 2'd1;
          if (win == SRC_ARP) ign_ipv4_d = 1'b1;
          else                ign_arp_d  = 1'b1;
        end else begin
          win = arp_start ? SRC_ARP : SRC_IPV4;
        end
        state_d     = (win == SRC_ARP) ? ST_GRANT_ARP : ST_GRANT_IPV4;
        last_d      = win;
        word_cnt_d  = '0;
        bus_d.start = 1'b1;
        mac_d       = (win == SRC_ARP) ? arp_tx_dst_mac : ipv4_tx_dst_mac;
        ethertype_d = (win == SRC_ARP) ? ETHERTYPE_ARP : ETHERTYPE_IPV4;
      end
    end else begin
      mac_d = grant_ipv4 ? ipv4_tx_dst_mac : arp_tx_dst_mac;
      if (o_start) begin
        coll_inc = coll_inc + 2'd1;
        if (grant_ipv4) ign_arp_d  = 1'b1;
        else            ign_ipv4_d = 1'b1;
      end
      if (g_term) begin
        state_d = ST_IDLE;
        // Starts are only accepted in IDLE, so a restart on the ending cycle is a collision.
        if (g_start) begin
          coll_inc = coll_inc + 2'd1;
          if (grant_ipv4) ign_ipv4_d = 1'b1;
          else            ign_arp_d  = 1'b1;
        end
        if (at_limit) begin
          bus_d.drop = 1'b1;
          tmo_d      = tmo_q + 32'd1;
        end else begin
          bus_d.data_valid  = g_bus.data_valid;
          bus_d.bytes_valid = g_bus.bytes_valid;
          bus_d.data        = g_bus.data;
          if (g_bus.drop) begin
            bus_d.drop = 1'b1;
          end else begin
            bus_d.commit = 1'b1;
            if (grant_ipv4) ipv4_sent_d = ipv4_sent_q + 32'd1;
            else            arp_sent_d  = arp_sent_q + 32'd1;
          end
        end
      end else if (g_start) begin
        bus_d.start       = 1'b1;
        bus_d.data_valid  = g_bus.data_valid;
        bus_d.bytes_valid = g_bus.bytes_valid;
        bus_d.data        = g_bus.data;
        word_cnt_d        = {15'd0, g_bus.data_valid};
      end else if (at_limit) begin
        bus_d.drop = 1'b1;
        tmo_d      = tmo_q + 32'd1;
        state_d    = ST_IDLE;
        if (grant_ipv4) ign_ipv4_d = 1'b1;
        else            ign_arp_d  = 1'b1;
      end else begin
        bus_d.data_valid  = g_bus.data_valid;
        bus_d.bytes_valid = g_bus.bytes_valid;
        bus_d.data        = g_bus.data;
        if (g_bus.data_valid) word_cnt_d = word_cnt_q + 16'd1;
      end
    end

    coll_d = coll_q + 32'(coll_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= SRC_IPV4;
      ign_arp_q   <= 1'b0;
      ign_ipv4_q  <= 1'b0;
      word_cnt_q  <= '0;
      bus_q       <= '0;
      mac_q       <= '0;
      ethertype_q <= '0;
      arp_sent_q  <= '0;
      ipv4_sent_q <= '0;
      coll_q      <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      ign_arp_q   <= ign_arp_d;
      ign_ipv4_q  <= ign_ipv4_d;
      word_cnt_q  <= word_cnt_d;
      bus_q       <= bus_d;
      mac_q       <= mac_d;
      ethertype_q <= ethertype_d;
      arp_sent_q  <= arp_sent_d;
      ipv4_sent_q <= ipv4_sent_d;
      coll_q      <= coll_d;
      tmo_q       <= tmo_d;
    end
  end

  assign tx_l2_bus       = bus_q;
  assign tx_l2_dst_mac   = mac_q;
  assign tx_l2_ethertype = ethertype_q;
  assign perf_arp_sent   = arp_sent_q;
  assign perf_ipv4_sent  = ipv4_sent_q;
  assign perf_collisions = coll_q;
  assign perf_timeouts   = tmo_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Testbench for eth_tx_arbiter: directed vector table, hand-written corner
// sequences and randomized frame traffic against a reference model.
module tb_eth_tx_arbiter;
  import eth_tx_arbiter_pkg::*;

  localparam int MAXW = 8;
  localparam logic [47:0] ARP_DST = 48'h02_00_00_00_00_01;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  EthernetBus  arp_bus, ip_bus, out_bus;
  logic [47:0] arp_mac, ip_mac, out_mac;
  logic [15:0] out_et;
  logic [31:0] p_arp, p_ip, p_col, p_to;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state: owner -1 = bus free, 0 = ARP, 1 = IPv4.
  int          owner, last, words;
  bit          ign [2];
  logic [31:0] m_sent [2];
  logic [31:0] m_col, m_tmo;
  EthernetBus  m_bus;
  logic [47:0] m_mac;
  logic [15:0] m_et;

  always #5 clk = ~clk;

  eth_tx_arbiter #(.MAX_FRAME_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .arp_tx_bus(arp_bus), .arp_tx_dst_mac(arp_mac),
    .ipv4_tx_bus(ip_bus), .ipv4_tx_dst_mac(ip_mac),
    .tx_l2_bus(out_bus), .tx_l2_dst_mac(out_mac), .tx_l2_ethertype(out_et),
    .perf_arp_sent(p_arp), .perf_ipv4_sent(p_ip),
    .perf_collisions(p_col), .perf_timeouts(p_to)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic EthernetBus mk(bit st, bit dv, bit cm, bit dr, logic [31:0] d);
    EthernetBus b;
    b = '0;
    b.start = st; b.data_valid = dv; b.bytes_valid = dv ? 3'd4 : 3'd0;
    b.data = d; b.commit = cm; b.drop = dr;
    return b;
  endfunction

  task automatic model_reset();
    owner = -1; last = 1; words = 0;
    ign[0] = 0; ign[1] = 0;
    m_sent[0] = '0; m_sent[1] = '0; m_col = '0; m_tmo = '0;
    m_bus = '0; m_mac = '0; m_et = '0;
  endtask

  task automatic model_fwd(input EthernetBus b);
    m_bus.data_valid = b.data_valid;
    m_bus.bytes_valid = b.bytes_valid;
    m_bus.data = b.data;
  endtask

  // One clock of the behavioural model, computed from the inputs about to be sampled.
  task automatic model_step();
    EthernetBus  in_b [2];
    logic [47:0] mac [2];
    bit          st [2];
    bit          term [2];
    int          g, o, win;
    in_b[0] = arp_bus; in_b[1] = ip_bus; mac[0] = arp_mac; mac[1] = ip_mac;
    m_bus = '0;
    for (int s = 0; s < 2; s++) begin
      term[s] = in_b[s].commit || in_b[s].drop;
      st[s] = in_b[s].start;
      if (ign[s]) begin
        st[s] = st[s] && term[s];
        if (term[s]) ign[s] = 0;
      end
    end
    if (owner < 0) begin
      win = -1;
      if (st[0] && st[1]) begin win = 1 - last; ign[last] = 1; m_col++; end
      else if (st[0]) win = 0;
      else if (st[1]) win = 1;
      if (win >= 0) begin
        owner = win; last = win; words = 0; m_bus.start = 1;
        m_mac = mac[win];
        m_et = (win == 0) ? 16'h0806 : 16'h0800;
      end
    end else begin
      g = owner; o = 1 - g; m_mac = mac[g];
      if (st[o]) begin m_col++; ign[o] = 1; end
      if (term[g]) begin
        owner = -1;
        if (st[g]) begin m_col++; ign[g] = 1; end
        if (in_b[g].data_valid && words == MAXW) begin m_bus.drop = 1; m_tmo++; end
        else begin
          model_fwd(in_b[g]);
          if (in_b[g].drop) m_bus.drop = 1;
          else begin m_bus.commit = 1; m_sent[g]++; end
        end
      end else if (st[g]) begin
        model_fwd(in_b[g]); m_bus.start = 1;
        words = in_b[g].data_valid ? 1 : 0;
      end else if (in_b[g].data_valid && words == MAXW) begin
        m_bus.drop = 1; m_tmo++; owner = -1; ign[g] = 1;
      end else begin
        model_fwd(in_b[g]);
        if (in_b[g].data_valid) words++;
      end
    end
  endtask

  task automatic check_all();
    chk("bus", 64'(out_bus), 64'(m_bus));
    chk("dst_mac", 64'(out_mac), 64'(m_mac));
    chk("ethertype", 64'(out_et), 64'(m_et));
    chk("arp_sent", 64'(p_arp), 64'(m_sent[0]));
    chk("ipv4_sent", 64'(p_ip), 64'(m_sent[1]));
    chk("collisions", 64'(p_col), 64'(m_col));
    chk("timeouts", 64'(p_to), 64'(m_tmo));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic logic [3:0] strobes();
    return {out_bus.start, out_bus.data_valid, out_bus.commit, out_bus.drop};
  endfunction

  task automatic drive(input EthernetBus a, input EthernetBus i);
    arp_bus = a; ip_bus = i;
  endtask

  typedef struct {
    bit a_st, a_dv, a_cm, a_dr;
    bit i_st, i_dv, i_cm, i_dr;
    logic [3:0]  exp;   // {start, data_valid, commit, drop}
    bit          src;   // source whose data appears when data_valid expected
    logic [15:0] et;
  } vec_t;

  vec_t        vt [17];
  EthernetBus  rb [2];
  bit          inframe [2];
  int          r;
  logic [31:0] base;

  initial begin
    arp_bus = '0; ip_bus = '0; arp_mac = '0; ip_mac = '0;
    inframe[0] = 0; inframe[1] = 0;

    // Two ties back to back, then a lone 7-word ARP frame (dst set at word 4).
    vt[0]  = '{1,0,0,0, 1,0,0,0, 4'b1000, 0, 16'h0806};
    vt[1]  = '{0,1,0,0, 0,1,0,0, 4'b0100, 0, 16'h0806};
    vt[2]  = '{0,1,0,0, 0,1,0,0, 4'b0100, 0, 16'h0806};
    vt[3]  = '{0,0,1,0, 0,0,1,0, 4'b0010, 0, 16'h0806};
    vt[4]  = '{1,0,0,0, 1,0,0,0, 4'b1000, 1, 16'h0800};
    vt[5]  = '{0,1,0,0, 0,1,0,0, 4'b0100, 1, 16'h0800};
    vt[6]  = '{0,0,1,0, 0,1,0,0, 4'b0100, 1, 16'h0800};
    vt[7]  = '{0,0,0,0, 0,0,1,0, 4'b0010, 1, 16'h0800};
    vt[8]  = '{1,0,0,0, 0,0,0,0, 4'b1000, 0, 16'h0806};
    for (int k = 9; k < 16; k++) vt[k] = '{0,1,0,0, 0,0,0,0, 4'b0100, 0, 16'h0806};
    vt[16] = '{0,0,1,0, 0,0,0,0, 4'b0010, 0, 16'h0806};

    model_reset();
    #12;
    check_all();
    chk("reset_bus_zero", 64'(out_bus), 64'd0);
    chk("reset_et_zero", 64'(out_et), 64'd0);
    #5 rst_n = 1'b1;

    for (int k = 0; k < 17; k++) begin
      arp_mac = (k >= 12) ? ARP_DST : '0;
      drive(mk(vt[k].a_st, vt[k].a_dv, vt[k].a_cm, vt[k].a_dr, 32'hA000_0000 + 32'(k)),
            mk(vt[k].i_st, vt[k].i_dv, vt[k].i_cm, vt[k].i_dr, 32'hB000_0000 + 32'(k)));
      tick();
      chk($sformatf("vec%0d_strobes", k), 64'(strobes()), 64'(vt[k].exp));
      chk($sformatf("vec%0d_et", k), 64'(out_et), 64'(vt[k].et));
      if (vt[k].exp[2]) begin
        base = vt[k].src ? 32'hB000_0000 : 32'hA000_0000;
        chk($sformatf("vec%0d_data", k), 64'(out_bus.data), 64'(base + 32'(k)));
      end
    end
    chk("arp_dst_at_commit", 64'(out_mac), 64'(ARP_DST));
    chk("tbl_arp_sent", 64'(p_arp), 64'd2);
    chk("tbl_ipv4_sent", 64'(p_ip), 64'd1);
    chk("tbl_collisions", 64'(p_col), 64'd2);
    drive('0, '0); tick();
    chk("quiet_after_commit", 64'(strobes()), 64'd0);

    // IPv4 collides with an ARP frame that then drops.
    drive(mk(1,0,0,0,0), '0); tick();
    drive(mk(0,1,0,0,32'h11), mk(1,0,0,0,0)); tick();
    chk("colA_collision", 64'(p_col), 64'd3);
    drive(mk(0,1,0,0,32'h12), mk(0,1,0,0,32'h99)); tick();
    chk("colA_arp_word", 64'(out_bus.data), 64'h12);
    drive(mk(0,0,0,1,0), mk(0,1,0,0,32'h98)); tick();
    chk("colA_drop", 64'(strobes()), 64'b0001);
    drive('0, mk(0,1,0,0,32'h97)); tick();
    chk("colA_ignored_word", 64'(out_bus), 64'd0);
    drive('0, mk(0,0,1,0,0)); tick();
    chk("colA_ignored_commit", 64'(out_bus), 64'd0);
    drive('0, mk(1,0,0,0,0)); tick();
    chk("colA_next_start", 64'(strobes()), 64'b1000);
    chk("colA_next_et", 64'(out_et), 64'h0800);
    drive('0, mk(0,1,0,0,32'h55)); tick();
    drive('0, mk(0,0,1,0,0)); tick();
    chk("colA_ipv4_sent", 64'(p_ip), 64'd2);

    // Watchdog: 12-word IPv4 frame with limit 8.
    drive('0, mk(1,0,0,0,0)); tick();
    for (int w = 1; w <= 12; w++) begin
      drive('0, mk(0,1,0,0,32'(w))); tick();
      if (w <= MAXW) begin
        chk($sformatf("wd_word%0d", w), 64'(strobes()), 64'b0100);
        chk($sformatf("wd_data%0d", w), 64'(out_bus.data), 64'(w));
      end else if (w == MAXW + 1) chk("wd_drop", 64'(strobes()), 64'b0001);
      else chk($sformatf("wd_trail%0d", w), 64'(out_bus), 64'd0);
    end
    drive('0, mk(0,0,1,0,0)); tick();
    chk("wd_commit_hidden", 64'(out_bus), 64'd0);
    chk("wd_timeouts", 64'(p_to), 64'd1);
    chk("wd_ipv4_sent", 64'(p_ip), 64'd2);

    // Commit and drop together: drop wins, nothing counted.
    drive(mk(1,0,0,0,0), '0); tick();
    drive(mk(0,1,0,0,32'h77), '0); tick();
    drive(mk(0,0,1,1,0), '0); tick();
    chk("cd_drop_only", 64'(strobes()), 64'b0001);
    chk("cd_no_sent", 64'(p_arp), 64'd2);
    drive('0, '0); tick();

    // Asynchronous reset mid-frame.
    drive(mk(1,0,0,0,0), '0); tick();
    drive(mk(0,1,0,0,32'h33), '0); tick();
    #2 rst_n = 1'b0;
    drive('0, '0);
    model_reset();
    #1;
    check_all();
    chk("rst_async_bus", 64'(out_bus), 64'd0);
    chk("rst_async_col", 64'(p_col), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #3 rst_n = 1'b1;
    drive(mk(1,0,0,0,0), mk(1,0,0,0,0)); tick();
    chk("rst_tie_arp", 64'(out_et), 64'h0806);
    drive(mk(0,0,1,0,0), mk(0,0,1,0,0)); tick();
    drive('0, '0); tick();

    // Randomized frame traffic from both sources.
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < 2; s++) begin
        r = int'($urandom_range(99));
        rb[s] = '0;
        if (!inframe[s]) begin
          if (r < 25) begin rb[s].start = 1'b1; inframe[s] = 1; end
        end else if (r < 60) begin
          rb[s].data_valid = 1'b1;
          rb[s].bytes_valid = 3'($urandom_range(4, 1));
          rb[s].data = $urandom;
        end else if (r < 78) begin rb[s].commit = 1'b1; inframe[s] = 0; end
        else if (r < 84) begin rb[s].drop = 1'b1; inframe[s] = 0; end
        else if (r < 86) begin rb[s].commit = 1'b1; rb[s].drop = 1'b1; inframe[s] = 0; end
        else if (r < 89) rb[s].start = 1'b1;
      end
      drive(rb[0], rb[1]);
      if ($urandom_range(9) == 0) arp_mac = 48'({$urandom, $urandom});
      if ($urandom_range(9) == 0) ip_mac = 48'({$urandom, $urandom});
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Shares the single layer-2 transmit bus between the ARP responder and the IPv4 transmit path. Each source streams a frame with no backpressure (start, data words, then commit or drop). The arbiter locks the output to whichever source starts first. It forwards that frame word-for-word with one cycle of latency, and rejects and counts any frame that collides with the one in flight. A watchdog aborts frames that never terminate.

## Interface
Parameters:
- MAX_FRAME_WORDS, 400: number of granted data words allowed before the frame is force-dropped (1600 bytes at 4 bytes/word).

Ports:
- clk  in  1  transmit clock; the only clock.
- rst_n  in  1  reset; asynchronous, active-low.
- arp_tx_bus  in  EthernetBus  ARP source (start, data_valid, bytes_valid, data[31:0], commit, drop).
- arp_tx_dst_mac  in  48  ARP destination MAC; may change mid-frame.
- ipv4_tx_bus  in  EthernetBus  IPv4 source.
- ipv4_tx_dst_mac  in  48  IPv4 destination MAC.
- tx_l2_bus  out  EthernetBus  arbitrated output to the MAC framer.
- tx_l2_dst_mac  out  48  destination MAC of the granted frame.
- tx_l2_ethertype  out  16  0x0806 while ARP is granted, 0x0800 while IPv4 is granted.
- perf_arp_sent, perf_ipv4_sent  out  32  frames committed to the output, per source; wrapping.
- perf_collisions  out  32  starts rejected because the bus was busy; wrapping.
- perf_timeouts  out  32  frames force-dropped by the watchdog; wrapping.

## Operation
- States: IDLE, GRANT_ARP, GRANT_IPV4.
- IDLE:
  - A source asserting start is granted. The state moves to GRANT_x and start is forwarded.
  - If both sources assert start in the same cycle, the grant alternates: the source not granted last time wins.
  - The loser counts one collision, and its frame is ignored until its own commit or drop.
  - After reset the "last granted" pointer is IPV4, so ARP wins the first tie.
- GRANT_x:
  - data_valid, bytes_valid, data, commit and drop from the granted source are forwarded.
  - dst_mac from the granted source is forwarded every cycle. ARP fills in its destination late in the frame, so the value only needs to be valid at commit.
  - Commit forwards commit, increments perf_x_sent, and returns to IDLE.
  - Drop forwards drop and returns to IDLE.
  - Commit and drop in the same cycle: drop wins. Forward drop only; no counter increments.
  - Start from the granted source mid-frame: forward start, reset the word counter, keep the grant. Downstream treats this as an abort-and-restart.
  - Start from the non-granted source: count one collision, ignore that frame until its commit or drop. This is tracked by a per-source "ignoring" flag.
  - A start arriving in the same cycle as the granted frame's commit or drop is rejected and counted as a collision. Starts are accepted only in IDLE.
- Watchdog:
  - The word counter increments on each granted data_valid.
  - When data_valid arrives with the counter already at MAX_FRAME_WORDS, do not forward that word. Forward drop instead, increment perf_timeouts, and return to IDLE.
  - The source's remaining words are ignored until its own commit or drop.
- Ignored source:
  - All of its fields are discarded.
  - Its commit or drop clears the ignoring flag.
  - A new start from it while it is being ignored is processed by the normal rules after the flag clears in the same cycle: granted if the arbiter is IDLE, otherwise a collision.
- Ethertype output is driven from the grant state and is held at its last value in IDLE.

## Timing
- All outputs are registered. Latency from any input field to its output is exactly 1 cycle.
- In the cycle after an output commit or drop, the only output strobe that can assert is start.
- Reset values:
  - tx_l2_bus all fields 0.
  - tx_l2_dst_mac 0.
  - tx_l2_ethertype 0x0000.
  - All perf counters 0.
  - State IDLE, ignoring flags 0, word counter 0.
- Reset asserted mid-frame: outputs clear asynchronously and no drop is emitted. Downstream must discard partial frames on its own reset.
- The word counter is 16 bits and saturates at MAX_FRAME_WORDS. MAX_FRAME_WORDS must be at most 65535.
- Perf counters wrap modulo 2^32.

## Structure
- Shared package holds:
  - ETHERTYPE_ARP and ETHERTYPE_IPV4.
  - An enum for the arbiter states.
  - An enum for the source index.
- EthernetBus is taken from the existing EthernetBus.svh.
- No sub-module. Grant logic, watchdog and counters are small enough to stay in one file.

## Test plan
- ARP frame alone (start, 7 words, commit, dst 02:00:00:00:00:01 set at word 4) -> output identical 1 cycle later, dst 02:00:00:00:00:01 at commit, ethertype 0x0806, perf_arp_sent=1.
- ARP and IPv4 start in the same cycle, twice in a row -> first tie granted to ARP, second to IPv4; perf_collisions=2; only the winners' words appear on the output.
- IPv4 start while an ARP frame is granted; ARP then drops -> output drop, no IPv4 data forwarded; IPv4 is ignored until its commit; the next IPv4 start is granted.
- With MAX_FRAME_WORDS=8, an IPv4 frame of 12 words -> 8 words forwarded, then drop on the 9th word's cycle; perf_timeouts=1; the trailing words and the commit are not forwarded.
- Commit and drop in the same cycle, plus rst_n pulsed mid-frame -> output drop only with no sent increment; reset clears all outputs and counters to 0 and returns to IDLE.
